alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Sequential ALU execute stage: the responder side of the ALU operand/result interface.
//  Accepts {OP, InputA, InputB, SC_in} under a valid/ready handshake and returns a registered
//  {Out, Zero, SC_out} under a second valid/ready handshake.
//  Multi-bit shifts run iteratively, one bit per cycle; all other ops complete in one cycle.
//  Sits between decode and writeback in basic_proc; opcodes come from definitions.
// PARAMETERS
//  W          8   datapath width (Out, InputA, InputB)
//  SHAMT_W    3   shift-amount field width, = $clog2(W); amount taken from InputB[SHAMT_W-1:0]
// PORTS
//  Clk        in   1   clock; all state updates on posedge
//  Reset_n    in   1   asynchronous, active-low reset
//  InValid    in   1   operand bundle valid
//  InReady    out  1   unit can accept a bundle
//  OP         in   4   opcode (definitions)
//  InputA     in   W   operand A
//  InputB     in   W   operand B / shift amount
//  SC_in      in   1   shift-carry fill bit for LSH/RSH
//  OutValid   out  1   result valid
//  OutReady   in   1   consumer takes result
//  Out        out  W   result
//  Zero       out  1   Out == 0
//  SC_out     out  1   ADD carry-out / last bit shifted out
//  IllegalOp  out  1   opcode not supported
// BEHAVIOUR
//  Reset: state IDLE; Out=0, Zero=0, SC_out=0, OutValid=0, IllegalOp=0, InReady=1 once released.
//   Reset asserted mid-op aborts immediately; partial result is discarded.
//  FSM: IDLE -> (accept) -> SHIFT or DONE; SHIFT -> DONE when count hits 0;
//   DONE -> IDLE on OutValid&&OutReady.
//  InReady = (state==IDLE). Accept = InValid&&InReady; operands are captured at accept.
//   Inputs are ignored outside IDLE.
//  OutValid = (state==DONE). Out/Zero/SC_out/IllegalOp stay stable while OutValid&&!OutReady.
//   The next accept is possible only in the cycle after the DONE handshake; there is no overlap.
//  Latency (accept edge = cycle 0): non-shift ops -> OutValid at cycle 1.
//   LSH/RSH with n=InputB[SHAMT_W-1:0] -> OutValid at cycle max(n,1).
//  Ops, arithmetic modulo 2^W:
//   LSH 0000: n times {r[W-2:0],SC_in}; SC_out = last r[W-1] shifted out.
//   RSH 0001: n times {SC_in,r[W-1:1]}; SC_out = last r[0] shifted out.
//   n==0 (LSH or RSH): Out=A, SC_out=0.
//   AND 0010: A&B. OR 0011: bitwise A|B. ADD 1011: A+B; SC_out = carry. NEG 1010: ~A+1 (0x80->0x80).
//   GEQ 1000 (unsigned), EQ 1001, NEQ 1101: Out = {W-1'b0, cond}.
//   SC_out=0 for all non-shift, non-ADD ops.
//  Any other opcode: Out=0, Zero=1, IllegalOp=1, latency 1.
//  Zero is computed from the final Out and registered with it.
// CONFIGURATION
//  ALU_SUB_EN defined: OP 1100 = SUB, Out = A-B mod 2^W, SC_out = borrow (A<B), latency 1.
//  ALU_SUB_EN undefined: 1100 is illegal, handled as any unsupported opcode above.
// TESTING
//  1. ADD A=8'hFF B=8'h01, OutReady=1 -> cycle 1: Out=00, Zero=1, SC_out=1, IllegalOp=0.
//  2. LSH A=8'h81 B=3 SC_in=1 -> InReady=0 cycles 0-2; cycle 3: Out=8'h0F, SC_out=0.
//     RSH A=8'h01 B=0 -> cycle 1: Out=01, SC_out=0.
//  3. GEQ A=3 B=4 -> Out=00, Zero=1; EQ 2,2 -> Out=01; NEQ 1,3 -> 01; NEG 1 -> FF; OR 1,0 -> 01.
//  4. Backpressure: AND 8'hF0,8'h3C with OutReady=0 for 4 cycles -> Out=30 held stable,
//     InValid ignored; OutReady=1 -> IDLE next cycle.
//  5. Reset_n low during LSH B=7 at cycle 3 -> outputs 0 asynchronously; after release
//     a new ADD 2+3 -> Out=05.
//  6. OP=1100 A=5 B=7: with ALU_SUB_EN -> Out=FE, SC_out=1; without it -> Out=00, IllegalOp=1.

Source files
------------

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: sequential ALU execute stage with valid/ready handshakes
// on both the operand side and the result side.
// Shifts by n run one bit per cycle. The first bit is shifted at the accept edge.
// All other operations finish at the accept edge.
// Optional feature macro: ALU_SUB_EN enables OP 4'b1100 = SUB (A-B, SC_out = borrow).
// When ALU_SUB_EN is undefined, OP 4'b1100 is treated as an illegal opcode.
module alu_exec_unit #(
  parameter int W       = 8,
  parameter int SHAMT_W = 3
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               InValid,
  output logic               InReady,
  input  logic [3:0]         OP,
  input  logic [W-1:0]       InputA,
  input  logic [W-1:0]       InputB,
  input  logic               SC_in,
  output logic               OutValid,
  input  logic               OutReady,
  output logic [W-1:0]       Out,
  output logic               Zero,
  output logic               SC_out,
  output logic               IllegalOp
);

  localparam logic [3:0] OP_LSH = 4'b0000;
  localparam logic [3:0] OP_RSH = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_GEQ = 4'b1000;
  localparam logic [3:0] OP_EQ  = 4'b1001;
  localparam logic [3:0] OP_NEG = 4'b1010;
  localparam logic [3:0] OP_ADD = 4'b1011;
`ifdef ALU_SUB_EN
  localparam logic [3:0] OP_SUB = 4'b1100;
`endif
  localparam logic [3:0] OP_NEQ = 4'b1101;

  localparam logic [W-1:0]       ZERO_W  = {W{1'b0}};
  localparam logic [W-1:0]       ONE_W   = {{(W-1){1'b0}}, 1'b1};
  localparam logic [SHAMT_W-1:0] CNT_ONE = {{(SHAMT_W-1){1'b0}}, 1'b1};
  localparam logic [SHAMT_W-1:0] CNT_ZERO = {SHAMT_W{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       res_q, res_d;
  logic               sc_q, sc_d;
  logic               zero_q, zero_d;
  logic               ill_q, ill_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               dir_q, dir_d;    // 1 = shift right
  logic               fill_q, fill_d;  // bit shifted in

  logic               accept_s;
  logic               is_shift_s;
  logic [SHAMT_W-1:0] shamt_s;
  logic [W:0]         sum_s;

  assign accept_s   = InValid && (state_q == S_IDLE);
  assign is_shift_s = (OP == OP_LSH) || (OP == OP_RSH);
  assign shamt_s    = InputB[SHAMT_W-1:0];
  assign sum_s      = {1'b0, InputA} + {1'b0, InputB};

  // State register: abort any operation as soon as reset is asserted.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: long shifts park in SHIFT and everything else goes straight to DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (InValid) begin
          if (is_shift_s && (shamt_s > CNT_ONE)) begin
            state_d = S_SHIFT;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (cnt_q == CNT_ONE) begin
          state_d = S_DONE;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_DONE: begin
        if (OutReady) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: compute at accept, shift one bit per SHIFT cycle, and hold otherwise.
  always_comb begin
    res_d  = res_q;
    sc_d   = sc_q;
    zero_d = zero_q;
    ill_d  = ill_q;
    cnt_d  = cnt_q;
    dir_d  = dir_q;
    fill_d = fill_q;
    if (accept_s) begin
      dir_d  = OP[0];
      fill_d = SC_in;
      ill_d  = 1'b0;
      sc_d   = 1'b0;
      cnt_d  = (shamt_s == CNT_ZERO) ? CNT_ZERO : (shamt_s - CNT_ONE);
      case (OP)
        OP_LSH: begin
          if (shamt_s == CNT_ZERO) begin
            res_d = InputA;
          end else begin
            res_d = {InputA[W-2:0], SC_in};
            sc_d  = InputA[W-1];
          end
        end
        OP_RSH: begin
          if (shamt_s == CNT_ZERO) begin
            res_d = InputA;
          end else begin
            res_d = {SC_in, InputA[W-1:1]};
            sc_d  = InputA[0];
          end
        end
        OP_AND: res_d = InputA & InputB;
        OP_OR:  res_d = InputA | InputB;
        OP_GEQ: res_d = {{(W-1){1'b0}}, (InputA >= InputB)};
        OP_EQ:  res_d = {{(W-1){1'b0}}, (InputA == InputB)};
        OP_NEQ: res_d = {{(W-1){1'b0}}, (InputA != InputB)};
        OP_NEG: res_d = ~InputA + ONE_W;
        OP_ADD: begin
          res_d = sum_s[W-1:0];
          sc_d  = sum_s[W];
        end
`ifdef ALU_SUB_EN
        OP_SUB: begin
          res_d = InputA - InputB;
          sc_d  = (InputA < InputB);
        end
`endif
        default: begin
          res_d = ZERO_W;
          ill_d = 1'b1;
        end
      endcase
      zero_d = (res_d == ZERO_W);
    end else if (state_q == S_SHIFT) begin
      if (dir_q) begin
        res_d = {fill_q, res_q[W-1:1]};
        sc_d  = res_q[0];
      end else begin
        res_d = {res_q[W-2:0], fill_q};
        sc_d  = res_q[W-1];
      end
      cnt_d  = cnt_q - CNT_ONE;
      zero_d = (res_d == ZERO_W);
    end else begin
      res_d = res_q;
    end
  end

  // Datapath registers: cleared by reset, which also discards any partial shift result.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      res_q  <= ZERO_W;
      sc_q   <= 1'b0;
      zero_q <= 1'b0;
      ill_q  <= 1'b0;
      cnt_q  <= CNT_ZERO;
      dir_q  <= 1'b0;
      fill_q <= 1'b0;
    end else begin
      res_q  <= res_d;
      sc_q   <= sc_d;
      zero_q <= zero_d;
      ill_q  <= ill_d;
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      fill_q <= fill_d;
    end
  end

  // Output decode: handshake flags come from the state register and results come from registers.
  always_comb begin
    InReady   = (state_q == S_IDLE);
    OutValid  = (state_q == S_DONE);
    Out       = res_q;
    Zero      = zero_q;
    SC_out    = sc_q;
    IllegalOp = ill_q;
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases followed by random operations.
// Every result is checked against a behavioural model.
module tb_alu_exec_unit;

  logic       Clk, Reset_n, InValid, InReady, SC_in, OutValid, OutReady;
  logic       Zero, SC_out, IllegalOp;
  logic [3:0] OP;
  logic [7:0] InputA, InputB, Out;

  int total = 0;
  int bad   = 0;

  alu_exec_unit #(.W(8), .SHAMT_W(3)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .InValid(InValid), .InReady(InReady),
    .OP(OP), .InputA(InputA), .InputB(InputB), .SC_in(SC_in),
    .OutValid(OutValid), .OutReady(OutReady), .Out(Out), .Zero(Zero),
    .SC_out(SC_out), .IllegalOp(IllegalOp)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model built from the arithmetic definition of each opcode.
  function automatic void model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                input logic sci, output logic [7:0] o, output logic c,
                                output logic il, output int lat);
    int n, ai, bi, v, fill;
    n = int'(b[2:0]); ai = int'(a); bi = int'(b);
    o = 8'h00; c = 1'b0; il = 1'b0; lat = 1;
    case (op)
      4'b0000: begin
        lat  = (n > 0) ? n : 1;
        fill = sci ? ((1 << n) - 1) : 0;
        v    = (ai << n) | fill;
        o    = 8'(v & 255);
        c    = (n > 0) ? 1'((v >> 8) & 1) : 1'b0;
      end
      4'b0001: begin
        lat  = (n > 0) ? n : 1;
        fill = sci ? ((255 << (8 - n)) & 255) : 0;
        o    = 8'(((ai >> n) | fill) & 255);
        c    = (n > 0) ? 1'((ai >> (n - 1)) & 1) : 1'b0;
      end
      4'b0010: o = a & b;
      4'b0011: o = a | b;
      4'b1000: o = (ai >= bi) ? 8'h01 : 8'h00;
      4'b1001: o = (ai == bi) ? 8'h01 : 8'h00;
      4'b1101: o = (ai != bi) ? 8'h01 : 8'h00;
      4'b1010: o = 8'((256 - ai) & 255);
      4'b1011: begin
        o = 8'((ai + bi) & 255);
        c = (ai + bi > 255);
      end
`ifdef ALU_SUB_EN
      4'b1100: begin
        o = 8'((ai - bi + 256) & 255);
        c = (ai < bi);
      end
`endif
      default: il = 1'b1;
    endcase
  endfunction

  // Issue one operation, hold the result for 'hold' cycles, then retire it and check every stage.
  task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic sci, input int hold);
    logic [7:0] eo;
    logic       ec, eil;
    int         elat, lat;
    bit         got;
    model(op, a, b, sci, eo, ec, eil, elat);
    chk("in_ready_idle", 32'(InReady), 32'(1'b1));
    OP = op; InputA = a; InputB = b; SC_in = sci; InValid = 1'b1;
    OutReady = (hold == 0);
    @(posedge Clk);
    #1;
    InValid = 1'b0;
    OP = 4'($urandom); InputA = 8'($urandom); InputB = 8'($urandom); SC_in = 1'($urandom);
    lat = 0; got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge Clk);
      lat++;
      if (OutValid) got = 1'b1;
    end
    chk("out_valid_seen", 32'(got), 32'(1'b1));
    chk("latency", 32'(lat), 32'(elat));
    chk("out", 32'(Out), 32'(eo));
    chk("zero", 32'(Zero), 32'(eo == 8'h00));
    chk("sc_out", 32'(SC_out), 32'(ec));
    chk("illegal", 32'(IllegalOp), 32'(eil));
    for (int i = 0; i < hold; i++) begin
      InValid = 1'b1;
      OP = 4'($urandom); InputA = 8'($urandom); InputB = 8'($urandom);
      @(negedge Clk);
      chk("hold_valid", 32'({OutValid, InReady}), 32'(2'b10));
      chk("hold_stable", 32'({Out, Zero, SC_out, IllegalOp}), 32'({eo, (eo == 8'h00), ec, eil}));
    end
    InValid = 1'b0;
    OutReady = 1'b1;
    @(negedge Clk);
    chk("retired", 32'({OutValid, InReady}), 32'(2'b01));
  endtask

  initial begin
    Reset_n = 1'b0; InValid = 1'b0; OutReady = 1'b0; OP = 4'h0;
    InputA = 8'h00; InputB = 8'h00; SC_in = 1'b0;
    repeat (2) @(negedge Clk);
    chk("rst_outputs", 32'({OutValid, Out, Zero, SC_out, IllegalOp}), 32'(12'h000));
    Reset_n = 1'b1;
    @(negedge Clk);

    // Directed cases.
    run_op(4'b1011, 8'hFF, 8'h01, 1'b0, 0);   // ADD with wrap and carry
    run_op(4'b0000, 8'h81, 8'h03, 1'b1, 0);   // LSH by 3 with one-fill
    run_op(4'b0001, 8'h01, 8'h00, 1'b1, 0);   // RSH by 0
    run_op(4'b0001, 8'hA5, 8'h07, 1'b0, 1);   // RSH by maximum amount
    run_op(4'b0000, 8'h80, 8'h01, 1'b0, 0);   // LSH by 1 to zero, carry 1
    run_op(4'b1000, 8'h03, 8'h04, 1'b0, 0);   // GEQ false
    run_op(4'b1000, 8'h04, 8'h04, 1'b0, 0);   // GEQ equal
    run_op(4'b1001, 8'h02, 8'h02, 1'b0, 0);   // EQ
    run_op(4'b1101, 8'h01, 8'h03, 1'b0, 0);   // NEQ
    run_op(4'b1010, 8'h01, 8'h00, 1'b0, 0);   // NEG 1
    run_op(4'b1010, 8'h80, 8'h00, 1'b0, 0);   // NEG of most-negative value
    run_op(4'b0011, 8'h01, 8'h00, 1'b0, 0);   // OR
    run_op(4'b0010, 8'hF0, 8'h3C, 1'b0, 4);   // AND under backpressure
    run_op(4'b1100, 8'h05, 8'h07, 1'b0, 0);   // SUB or illegal depending on build
    run_op(4'b1111, 8'h12, 8'h34, 1'b1, 1);   // illegal opcode

    // Reset in the middle of a long shift.
    OP = 4'b0000; InputA = 8'hFF; InputB = 8'h07; SC_in = 1'b1; InValid = 1'b1;
    @(posedge Clk);
    #1;
    InValid = 1'b0;
    repeat (3) @(negedge Clk);
    chk("mid_shift_busy", 32'({OutValid, InReady}), 32'(2'b00));
    #2;
    Reset_n = 1'b0;
    #1;
    chk("async_reset", 32'({OutValid, Out, Zero, SC_out, IllegalOp}), 32'(12'h000));
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    run_op(4'b1011, 8'h02, 8'h03, 1'b0, 0);   // ADD after reset

    // Random operations across all 16 opcodes.
    for (int k = 0; k < 60; k++) begin
      run_op(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 1'($urandom),
             int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
